// File: rtl/freq_mult_pkg.sv
// rtl/freq_mult_pkg.sv - shared constants and state encoding for the frequency multiplier
`timescale 1ns/1ps
package freq_mult_pkg;

  // Default width of the period counter and published period word
  localparam int DEF_CNT_W = 16;

  // Default log2 of the number of input periods averaged per measurement
  localparam int DEF_LOG2_AVG = 2;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } meas_state_t;

  // Saturation value of the counter at its default width
  localparam logic [DEF_CNT_W-1:0] CNT_SAT = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with a history flop and rising-edge pulse
`timescale 1ns/1ps
module edge_sync (
  input  logic RefClk,
  input  logic rst,
  input  logic async_in,
  output logic edge_det
);

  logic s1;
  logic s2;
  logic s3;

  // Resynchronise the asynchronous input and keep one cycle of history
  always_ff @(posedge RefClk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // One-cycle pulse on each synchronised low-to-high transition
  assign edge_det = s2 & ~s3;

endmodule

// File: rtl/in_period_meter.sv
// rtl/in_period_meter.sv - averaged InClk period measurement in RefClk cycles
`timescale 1ns/1ps
module in_period_meter
  import freq_mult_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOG2_AVG = DEF_LOG2_AVG
) (
  input  logic             RefClk,
  input  logic             rst,
  input  logic             InClk,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic             completed,
  output logic             overflow,
  output logic             busy
);

  localparam int ACC_W = CNT_W + LOG2_AVG;
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LOG2_AVG-1:0] PCNT_MAX = {LOG2_AVG{1'b1}};
  localparam logic [LOG2_AVG-1:0] PCNT_ONE = {{(LOG2_AVG-1){1'b0}}, 1'b1};

  meas_state_t         state;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    acc;
  logic [LOG2_AVG-1:0] pcnt;
  logic                start_q;
  logic                start_rise;
  logic                in_edge;
  logic [ACC_W-1:0]    acc_sum;

  edge_sync u_edge_sync (
    .RefClk  (RefClk),
    .rst     (rst),
    .async_in(InClk),
    .edge_det(in_edge)
  );

  // Running total including the sample that closes on this edge
  assign acc_sum = acc + {{LOG2_AVG{1'b0}}, cnt};

  // A held start only re-arms from IDLE/DONE; aborting a running
  // measurement needs a fresh request, so start tied high still completes
  assign start_rise = start & ~start_q;

  // Remember last cycle's start level for request detection
  always_ff @(posedge RefClk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // Measurement sequencer with registered outputs
  always_ff @(posedge RefClk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      pcnt      <= '0;
      period    <= '0;
      completed <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_ARM;
            completed <= 1'b0;
            overflow  <= 1'b0;
            acc       <= '0;
            pcnt      <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
          end
        end

        ST_ARM: begin
          if (start_rise) begin
            // restart: an edge in this same cycle is deliberately ignored
            acc  <= '0;
            pcnt <= '0;
            cnt  <= '0;
          end else if (in_edge) begin
            state <= ST_MEAS;
            cnt   <= CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            state     <= ST_DONE;
            overflow  <= 1'b1;
            period    <= CNT_MAX;
            completed <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_MEAS: begin
          if (start_rise) begin
            state <= ST_ARM;
            acc   <= '0;
            pcnt  <= '0;
            cnt   <= '0;
          end else if (in_edge) begin
            acc  <= acc_sum;
            cnt  <= CNT_ONE;
            pcnt <= pcnt + PCNT_ONE;
            if (pcnt == PCNT_MAX) begin
              state     <= ST_DONE;
              period    <= CNT_W'(acc_sum >> LOG2_AVG);
              completed <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (cnt == CNT_MAX) begin
            // counter saturates instead of wrapping
            state     <= ST_DONE;
            overflow  <= 1'b1;
            period    <= CNT_MAX;
            completed <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_period_meter.sv
// tb/tb_in_period_meter.sv - self-checking bench for in_period_meter
`timescale 1ns/1ps
module tb_in_period_meter;

  localparam int CW = 8;
  localparam int LA = 2;

  logic          RefClk = 1'b0;
  logic          rst    = 1'b0;
  logic          InClk  = 1'b0;
  logic          start  = 1'b0;
  logic [CW-1:0] period;
  logic          completed;
  logic          overflow;
  logic          busy;

  int cmp_n  = 0;
  int fail_n = 0;
  bit saw_comp;

  typedef struct {
    int p0;
    int p1;
    int p2;
    int p3;
    int exp_period;
  } vec_t;

  vec_t vecs[6];

  in_period_meter #(.CNT_W(CW), .LOG2_AVG(LA)) dut (
    .RefClk   (RefClk),
    .rst      (rst),
    .InClk    (InClk),
    .start    (start),
    .period   (period),
    .completed(completed),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 RefClk = ~RefClk;

  // Advance one cycle and sample 2ns after the edge
  task automatic tick();
    @(posedge RefClk);
    #2;
    if (completed) saw_comp = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_period(input int p);
    InClk = 1'b1;
    repeat (p / 2) tick();
    InClk = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  // Reference: average of the four intervals between consecutive rises, truncated
  task automatic measure(input string nm, input bit do_start, input int p0, input int p1,
                         input int p2, input int p3);
    int ps[4];
    int exp_p;
    int waited;
    ps    = '{p0, p1, p2, p3};
    exp_p = 0;
    foreach (ps[i]) exp_p += ps[i];
    exp_p = exp_p / 4;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, ".busy_armed"}, 32'(busy), 1);
    end
    saw_comp = 1'b0;
    foreach (ps[i]) drive_period(ps[i]);
    InClk = 1'b1;
    tick();
    tick();
    InClk = 1'b0;
    chk({nm, ".no_early_completed"}, 32'(saw_comp), 0);
    waited = 0;
    while (!completed && waited < 10) begin
      tick();
      waited++;
    end
    chk({nm, ".completed"}, 32'(completed), 1);
    chk({nm, ".latency_ok"}, 32'(waited <= 2), 1);
    chk({nm, ".period"}, 32'(period), 32'(exp_p));
    chk({nm, ".overflow"}, 32'(overflow), 0);
    chk({nm, ".busy_done"}, 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    int run;
    int r0, r1, r2, r3;

    vecs[0] = '{40, 40, 40, 40, 40};
    vecs[1] = '{39, 41, 39, 41, 40};
    vecs[2] = '{40, 40, 40, 41, 40};
    vecs[3] = '{10, 11, 12, 13, 11};
    vecs[4] = '{4, 4, 4, 4, 4};
    vecs[5] = '{100, 101, 102, 103, 101};

    // reset state
    tick();
    chk("reset.period", 32'(period), 0);
    chk("reset.completed", 32'(completed), 0);
    chk("reset.overflow", 32'(overflow), 0);
    chk("reset.busy", 32'(busy), 0);
    rst = 1'b1;
    repeat (3) tick();

    // table-driven constant and mixed periods
    for (int i = 0; i < 6; i++) begin
      measure($sformatf("vec%0d", i), 1'b1, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      chk($sformatf("vec%0d.table", i), 32'(period), 32'(vecs[i].exp_period));
    end

    // randomized periods against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      r0 = $urandom_range(120, 4);
      r1 = $urandom_range(120, 4);
      r2 = $urandom_range(120, 4);
      r3 = $urandom_range(120, 4);
      measure($sformatf("rnd%0d", i), 1'b1, r0, r1, r2, r3);
    end

    // InClk stuck low -> saturation
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!completed && n < 300) begin
      tick();
      n++;
    end
    chk("ovf.completed", 32'(completed), 1);
    chk("ovf.overflow", 32'(overflow), 1);
    chk("ovf.period", 32'(period), 255);
    chk("ovf.busy", 32'(busy), 0);
    chk("ovf.cycles_near_255", 32'(n >= 254 && n <= 258), 1);

    // abort mid-measurement, then a different input period
    start = 1'b1;
    tick();
    start = 1'b0;
    saw_comp = 1'b0;
    drive_period(40);
    drive_period(40);
    repeat (10) tick();
    chk("abort.period_held", 32'(period), 255);
    chk("abort.no_completed", 32'(saw_comp), 0);
    chk("abort.busy", 32'(busy), 1);
    measure("abort", 1'b1, 60, 60, 60, 60);

    // reset mid-measurement
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_period(40);
    drive_period(40);
    rst = 1'b0;
    #1;
    chk("midrst.period", 32'(period), 0);
    chk("midrst.completed", 32'(completed), 0);
    chk("midrst.overflow", 32'(overflow), 0);
    chk("midrst.busy", 32'(busy), 0);
    tick();
    rst = 1'b1;
    tick();
    measure("after_rst", 1'b1, 30, 30, 30, 30);

    // start held high: back-to-back measurements with one-cycle completed
    start  = 1'b1;
    pulses = 0;
    run    = 0;
    for (int c = 0; c < 400; c++) begin
      InClk = ((c % 20) < 10);
      tick();
      if (completed) begin
        if (run == 0) begin
          pulses++;
          chk("held.period", 32'(period), 20);
          chk("held.overflow", 32'(overflow), 0);
        end
        run++;
      end else if (run > 0) begin
        chk("held.pulse_width", 32'(run), 1);
        run = 0;
      end
    end
    chk("held.pulses_ge3", 32'(pulses >= 3), 1);
    start = 1'b0;
    InClk = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

// File: doc/in_period_meter.md
Name: in_period_meter

Overview:
- Measurement front-end of the frequency multiplier; sits directly upstream of the multiplier control unit.
- Measures the period of the external input clock InClk in RefClk cycles, averaged over 2^LOG2_AVG input periods.
- Raises `completed`, which the control unit waits on before computing the ratio and preloading the clock divider.
- Also publishes the averaged period word consumed by the ratio/divider datapath.

Parameters:
- CNT_W, 16: width of the period counter and of the `period` output.
- LOG2_AVG, 2: log2 of the number of input periods averaged (2 -> 4 periods).

Ports:
- RefClk  input  1  reference clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- InClk  input  1  clock being measured; asynchronous to RefClk.
- start  input  1  request a new measurement; level sampled each RefClk cycle.
- period  output  CNT_W  averaged input period in RefClk cycles; held until the next measurement completes.
- completed  output  1  measurement valid; level, held high until the next accepted start.
- overflow  output  1  no InClk edge within 2^CNT_W-1 cycles; valid while completed=1.
- busy  output  1  high in ARM or MEAS.

Behaviour:
Reset (rst=0, async):
- state=IDLE; period, completed, overflow, busy all 0.
- Counters, accumulator and synchronizer flops all 0.

Input synchronisation and edge detection:
- InClk passes through a 2-flop synchronizer plus one history flop: s1 -> s2 -> s3.
- `edge` = s2 & ~s3, a one-cycle pulse.
- An InClk rise is seen as `edge` 2-3 RefClk cycles later.
- Pulse widths of 2 or more RefClk cycles high and 2 or more low are required. Narrower pulses may be missed; this is not detected.

Internal registers:
- cnt: CNT_W bits.
- acc: CNT_W+LOG2_AVG bits.
- pcnt: LOG2_AVG bits.

States:
- IDLE: busy=0.
  - start=1 -> ARM; clear completed, overflow, acc and pcnt; cnt=0.
- ARM: waiting for the first edge; cnt increments each cycle.
  - edge -> MEAS with cnt=1.
  - cnt reaching all-ones -> DONE with overflow=1 and period=all-ones.
- MEAS, no edge: cnt increments.
  - If cnt==all-ones -> DONE with overflow=1 and period=all-ones; cnt never wraps.
- MEAS, edge:
  - acc += cnt; cnt=1; pcnt increments.
  - If pcnt was 2^LOG2_AVG-1 -> DONE with period = (acc+cnt)>>LOG2_AVG, computed at full width and truncated to CNT_W.
- DONE: completed=1, busy=0.
  - start=1 -> ARM; completed and overflow drop the next cycle.

Timing and numeric rules:
- For a constant input period of P RefClk cycles, each sample equals P exactly.
- period and completed are updated on the RefClk edge that samples the final `edge` pulse, i.e. 1 cycle of latency after `edge`.
- Averaging truncates toward zero.

Boundary cases:
- start=1 while in ARM or MEAS: abort and restart; clear acc, pcnt, cnt; stay in or return to ARM. period keeps its old value.
- start held high continuously: after DONE, a new measurement begins immediately; completed is high for exactly 1 cycle.
- edge in the same cycle as start: start wins; that edge is ignored.
- Reset mid-operation: immediate return to reset values; no partial result is published.

Decomposition:
Package freq_mult_pkg holds:
- the state encoding (IDLE=0, ARM=1, MEAS=2, DONE=3) as 2-bit constants;
- default CNT_W and LOG2_AVG;
- the saturation constant {CNT_W{1'b1}}.

Sub-module edge_sync contains the synchronizer and rising-edge detector.
- Ports: RefClk, rst, async_in, edge.
- The control unit reuses it for `adjust` debouncing.

Test Plan:
1. Reset release, InClk period 40 RefClk, start pulse 1 cycle -> busy=1, then after the 5th edge period=40, completed=1, overflow=0. completed is seen within 5*40+4 cycles.
2. InClk periods alternating 39/41, 4 samples -> period=40. Then periods 40,40,40,41 (sum 161) -> period=40 (truncation).
3. InClk held low after start, CNT_W=8 build -> after 255 cycles overflow=1, period=8'hFF, completed=1, busy=0.
4. start re-asserted mid-MEAS after 2 periods of 40, then InClk changed to 60 -> period=60, never a 40/60 mix; period holds its prior value until the new completion.
5. rst driven low mid-MEAS for 1 cycle -> period=0, completed=0, overflow=0, busy=0 immediately; the next start gives a correct fresh measurement.
6. start tied high, InClk period 20 -> completed pulses high for 1 cycle every measurement, period=20 each time.
